// File: rtl/vector_lane_scheduler.sv
// vector_lane_scheduler: fetches operand pairs for one vector op
// and dispatches them round-robin across the functional lanes.
module vector_lane_scheduler #(
  parameter int NUM_OF_LANES = 4,
  parameter int DATA_W       = 64,
  parameter int LEN_W        = 32,
  parameter int REG_PTR_W    = 5,
  parameter int OP_W         = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_vld,
  output logic                    cmd_rdy,
  input  logic [OP_W-1:0]         cmd_op,
  input  logic [REG_PTR_W-1:0]    cmd_src0,
  input  logic [REG_PTR_W-1:0]    cmd_src1,
  input  logic [REG_PTR_W-1:0]    cmd_dst,
  input  logic [LEN_W-1:0]        cmd_len,
  output logic                    rd_req_vld,
  input  logic                    rd_req_rdy,
  output logic [REG_PTR_W-1:0]    rd_req_ptr0,
  output logic [REG_PTR_W-1:0]    rd_req_ptr1,
  output logic [LEN_W-1:0]        rd_req_idx,
  input  logic                    rd_rsp_vld,
  input  logic [DATA_W-1:0]       rd_rsp_data0,
  input  logic [DATA_W-1:0]       rd_rsp_data1,
  output logic [NUM_OF_LANES-1:0] lane_vld,
  output logic [DATA_W-1:0]       lane_data0,
  output logic [DATA_W-1:0]       lane_data1,
  output logic [OP_W-1:0]         lane_op,
  output logic [REG_PTR_W-1:0]    lane_dst,
  output logic [LEN_W-1:0]        lane_idx,
  input  logic [NUM_OF_LANES-1:0] lane_busy,
  input  logic [NUM_OF_LANES-1:0] lane_done,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int LANE_W =
    (NUM_OF_LANES > 1) ? $clog2(NUM_OF_LANES) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CW    = LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [LEN_W-1:0]  idx;
  } pair_t;

  state_t state_q, state_n;

  logic [OP_W-1:0]         op_q;
  logic [REG_PTR_W-1:0]    dst_q;
  logic [CW-1:0]           len_q;
  logic [CW-1:0]           req_q;
  logic [CW-1:0]           disp_q;
  logic [CW-1:0]           cmp_q;
  logic [LEN_W-1:0]        rsp_idx_q;
  logic [CNT_W-1:0]        out_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [PTR_W-1:0]        wp_q;
  logic [PTR_W-1:0]        rp_q;
  pair_t                   mem_q [FIFO_DEPTH];
  logic [NUM_OF_LANES-1:0] infl_q;
  logic [LANE_W-1:0]       last_q;

  logic accept;
  logic hs;
  logic rsp_ok;
  logic rsp_bad;
  logic done_bad;
  logic empty;
  logic avail;
  logic disp;
  logic push;
  logic pop;
  logic found;
  logic done_n;
  logic vld_n;

  logic [NUM_OF_LANES-1:0] elig;
  logic [NUM_OF_LANES-1:0] good_done;
  logic [NUM_OF_LANES-1:0] sel_oh;
  logic [LANE_W-1:0]       sel;
  logic [LANE_W-1:0]       cand;

  pair_t rsp_pair;
  pair_t head;

  logic [CW-1:0]    req_n;
  logic [CW-1:0]    disp_n;
  logic [CW-1:0]    cmp_n;
  logic [CW-1:0]    cmp_inc;
  logic [CW-1:0]    len_n;
  logic [CNT_W-1:0] out_n;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W:0]   credit;

  assign cmd_rdy  = (state_q == IDLE);
  assign accept   = cmd_rdy && cmd_vld;
  assign hs       = rd_req_vld && rd_req_rdy;
  assign rsp_ok   = rd_rsp_vld && (out_q != '0);
  assign rsp_bad  = rd_rsp_vld && (out_q == '0);
  assign done_bad = |(lane_done & ~infl_q);
  assign empty    = (cnt_q == '0);
  assign elig     = ~lane_busy & ~infl_q;
  assign good_done = lane_done & infl_q;

  assign rsp_pair = {rd_rsp_data0, rd_rsp_data1, rsp_idx_q};
  assign head     = empty ? rsp_pair : mem_q[rp_q];
  assign avail    = !empty || rsp_ok;
  assign disp     = (state_q == RUN) && avail && found;
  assign push     = rsp_ok && !(disp && empty);
  assign pop      = disp && !empty;

  // round-robin pick starting just after the last served lane
  always_comb begin
    found  = 1'b0;
    sel    = '0;
    cand   = '0;
    sel_oh = '0;
    for (int k = 1; k <= NUM_OF_LANES; k++) begin
      cand = LANE_W'((int'(last_q) + k) % NUM_OF_LANES);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    if (disp) sel_oh[sel] = 1'b1;
  end

  // next values of counters and credit
  always_comb begin
    cmp_inc = '0;
    for (int i = 0; i < NUM_OF_LANES; i++) begin
      cmp_inc = cmp_inc + CW'(good_done[i]);
    end
    req_n  = accept ? '0 : req_q + CW'(hs);
    disp_n = accept ? '0 : disp_q + CW'(disp);
    cmp_n  = accept ? '0 : cmp_q + cmp_inc;
    len_n  = accept ? {1'b0, cmd_len} : len_q;
    out_n  = out_q + CNT_W'(hs) - CNT_W'(rsp_ok);
    cnt_n  = cnt_q + CNT_W'(push) - CNT_W'(pop);
    credit = {1'b0, out_n} + {1'b0, cnt_n};
  end

  // state transitions and done strobe
  always_comb begin
    state_n = state_q;
    done_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_len == '0) done_n = 1'b1;
          else               state_n = RUN;
        end
      end
      RUN: begin
        if (disp_n == len_q) state_n = DRAIN;
      end
      DRAIN: begin
        if (cmp_n == len_q) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    vld_n = (state_n == RUN) && (req_n < len_n) &&
            (credit < (CNT_W + 1)'(FIFO_DEPTH));
  end

  // control state, counters and lane bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      req_q     <= '0;
      disp_q    <= '0;
      cmp_q     <= '0;
      rsp_idx_q <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      infl_q    <= '0;
      last_q    <= LANE_W'(NUM_OF_LANES - 1);
    end else begin
      state_q <= state_n;
      if (accept) begin
        op_q  <= cmd_op;
        dst_q <= cmd_dst;
      end
      len_q  <= len_n;
      req_q  <= req_n;
      disp_q <= disp_n;
      cmp_q  <= cmp_n;
      out_q  <= out_n;
      cnt_q  <= cnt_n;
      if (accept)      rsp_idx_q <= '0;
      else if (rsp_ok) rsp_idx_q <= rsp_idx_q + 1'b1;
      wp_q   <= wp_q + PTR_W'(push);
      rp_q   <= rp_q + PTR_W'(pop);
      infl_q <= (infl_q & ~lane_done) | sel_oh;
      if (disp) last_q <= sel;
    end
  end

  // operand-pair buffer storage
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= rsp_pair;
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_req_vld  <= 1'b0;
      rd_req_ptr0 <= '0;
      rd_req_ptr1 <= '0;
      rd_req_idx  <= '0;
      lane_vld    <= '0;
      lane_data0  <= '0;
      lane_data1  <= '0;
      lane_op     <= '0;
      lane_dst    <= '0;
      lane_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      rd_req_vld <= vld_n;
      rd_req_idx <= req_n[LEN_W-1:0];
      if (accept) begin
        rd_req_ptr0 <= cmd_src0;
        rd_req_ptr1 <= cmd_src1;
      end
      lane_vld <= sel_oh;
      if (disp) begin
        lane_data0 <= head.d0;
        lane_data1 <= head.d1;
        lane_idx   <= head.idx;
        lane_op    <= op_q;
        lane_dst   <= dst_q;
      end
      busy <= (state_n != IDLE);
      done <= done_n;
      err  <= err | rsp_bad | done_bad;
    end
  end

endmodule

// File: tb/tb_vector_lane_scheduler.sv
// tb_vector_lane_scheduler: directed checks of the lane scheduler
// with a 2-cycle register file model and simple lane models.
module tb_vector_lane_scheduler;

  localparam int NL = 4;
  localparam int DW = 64;
  localparam int LW = 32;
  localparam int PW = 5;
  localparam int OW = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_vld;
  logic          cmd_rdy;
  logic [OW-1:0] cmd_op;
  logic [PW-1:0] cmd_src0;
  logic [PW-1:0] cmd_src1;
  logic [PW-1:0] cmd_dst;
  logic [LW-1:0] cmd_len;
  logic          rd_req_vld;
  logic          rd_req_rdy;
  logic [PW-1:0] rd_req_ptr0;
  logic [PW-1:0] rd_req_ptr1;
  logic [LW-1:0] rd_req_idx;
  logic          rd_rsp_vld;
  logic [DW-1:0] rd_rsp_data0;
  logic [DW-1:0] rd_rsp_data1;
  logic [NL-1:0] lane_vld;
  logic [DW-1:0] lane_data0;
  logic [DW-1:0] lane_data1;
  logic [OW-1:0] lane_op;
  logic [PW-1:0] lane_dst;
  logic [LW-1:0] lane_idx;
  logic [NL-1:0] lane_busy;
  logic [NL-1:0] lane_done;
  logic          busy;
  logic          done;
  logic          err;

  logic          inj_rsp;
  logic [NL-1:0] inj_done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vector_lane_scheduler #(
    .NUM_OF_LANES(NL),
    .DATA_W(DW),
    .LEN_W(LW),
    .REG_PTR_W(PW),
    .OP_W(OW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_vld(cmd_vld),
    .cmd_rdy(cmd_rdy),
    .cmd_op(cmd_op),
    .cmd_src0(cmd_src0),
    .cmd_src1(cmd_src1),
    .cmd_dst(cmd_dst),
    .cmd_len(cmd_len),
    .rd_req_vld(rd_req_vld),
    .rd_req_rdy(rd_req_rdy),
    .rd_req_ptr0(rd_req_ptr0),
    .rd_req_ptr1(rd_req_ptr1),
    .rd_req_idx(rd_req_idx),
    .rd_rsp_vld(rd_rsp_vld),
    .rd_rsp_data0(rd_rsp_data0),
    .rd_rsp_data1(rd_rsp_data1),
    .lane_vld(lane_vld),
    .lane_data0(lane_data0),
    .lane_data1(lane_data1),
    .lane_op(lane_op),
    .lane_dst(lane_dst),
    .lane_idx(lane_idx),
    .lane_busy(lane_busy),
    .lane_done(lane_done),
    .busy(busy),
    .done(done),
    .err(err)
  );

  function automatic logic [DW-1:0] f0(input logic [LW-1:0] i);
    return {32'hA5A5_0000, i};
  endfunction

  function automatic int lane_of(input logic [NL-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NL; i++) if (v[i]) r = i;
    return r;
  endfunction

  // register file: fixed 2-cycle in-order response pipe
  logic          s0_v = 1'b0;
  logic          s1_v = 1'b0;
  logic [LW-1:0] s0_i = '0;
  logic [LW-1:0] s1_i = '0;
  int            req_tot = 0;
  logic [LW-1:0] req_log [$];

  always @(posedge clk) begin
    if (reset) begin
      s0_v <= 1'b0;
      s1_v <= 1'b0;
    end else begin
      s0_v <= rd_req_vld && rd_req_rdy;
      s0_i <= rd_req_idx;
      s1_v <= s0_v;
      s1_i <= s0_i;
      if (rd_req_vld && rd_req_rdy) begin
        req_tot <= req_tot + 1;
        req_log.push_back(rd_req_idx);
      end
    end
  end

  assign rd_rsp_vld   = s1_v | inj_rsp;
  assign rd_rsp_data0 = f0(s1_i);
  assign rd_rsp_data1 = ~f0(s1_i);

  // lanes: each finishes dly cycles after its strobe
  int            timer [NL];
  int            dly;
  logic [NL-1:0] m_done;
  int            lane_log [$];
  logic [LW-1:0] idx_log [$];
  int            data_bad = 0;
  int            hot_bad  = 0;
  int            done_cnt = 0;
  logic [OW-1:0] cur_op;
  logic [PW-1:0] cur_dst;

  always_comb begin
    m_done = '0;
    for (int i = 0; i < NL; i++) m_done[i] = (timer[i] == 1);
  end

  assign lane_done = m_done | inj_done;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NL; i++) timer[i] <= 0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (lane_vld[i])       timer[i] <= dly;
        else if (timer[i] > 0) timer[i] <= timer[i] - 1;
      end
      if (lane_vld != '0) begin
        if (!$onehot(lane_vld)) hot_bad <= hot_bad + 1;
        lane_log.push_back(lane_of(lane_vld));
        idx_log.push_back(lane_idx);
        if (lane_data0 !== f0(lane_idx) ||
            lane_data1 !== ~f0(lane_idx) ||
            lane_op !== cur_op || lane_dst !== cur_dst)
          data_bad <= data_bad + 1;
      end
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [LW-1:0] len,
                       input logic [PW-1:0] s0,
                       input logic [PW-1:0] s1,
                       input logic [PW-1:0] d,
                       input logic [OW-1:0] op);
    cmd_vld  = 1'b1;
    cmd_len  = len;
    cmd_src0 = s0;
    cmd_src1 = s1;
    cmd_dst  = d;
    cmd_op   = op;
    cur_op   = op;
    cur_dst  = d;
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  int exp_rr [6];

  initial begin
    int b_req;
    int b_log;
    int b_done;
    int b_rl;
    int n;
    int bad;

    cmd_vld    = 1'b0;
    cmd_op     = '0;
    cmd_src0   = '0;
    cmd_src1   = '0;
    cmd_dst    = '0;
    cmd_len    = '0;
    rd_req_rdy = 1'b1;
    lane_busy  = '0;
    inj_rsp    = 1'b0;
    inj_done   = '0;
    dly        = 3;
    cur_op     = '0;
    cur_dst    = '0;
    exp_rr     = '{0, 2, 3, 0, 2, 3};

    repeat (3) @(negedge clk);
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_req_vld", rd_req_vld, 0);
    chk("rst_lane_vld", lane_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clk);

    // basic: len 4, all lanes free
    b_req  = req_tot;
    b_log  = lane_log.size();
    b_done = done_cnt;
    issue(4, 3, 7, 9, 8'h5A);
    chk("basic_busy", busy, 1);
    chk("basic_req_vld", rd_req_vld, 1);
    chk("basic_req_idx", rd_req_idx, 0);
    chk("basic_ptr0", rd_req_ptr0, 3);
    chk("basic_ptr1", rd_req_ptr1, 7);
    chk("basic_cmd_rdy", cmd_rdy, 0);
    wait_done("basic", 60);
    repeat (3) @(negedge clk);
    chk("basic_done_once", done_cnt - b_done, 1);
    chk("basic_nreq", req_tot - b_req, 4);
    chk("basic_ndisp", lane_log.size() - b_log, 4);
    for (int i = 0; i < 4; i++) begin
      chk("basic_lane", lane_log[b_log + i], i);
      chk("basic_idx", idx_log[b_log + i], i);
    end
    chk("basic_busy_after", busy, 0);

    // zero length
    b_req  = req_tot;
    b_done = done_cnt;
    issue(0, 4, 5, 6, 8'h11);
    chk("zl_done", done, 1);
    chk("zl_cmd_rdy", cmd_rdy, 1);
    chk("zl_busy", busy, 0);
    chk("zl_req_vld", rd_req_vld, 0);
    @(negedge clk);
    chk("zl_done_low", done, 0);
    repeat (3) @(negedge clk);
    chk("zl_no_req", req_tot - b_req, 0);
    chk("zl_done_once", done_cnt - b_done, 1);

    // round robin, lane 1 held busy
    lane_busy = 4'b0010;
    dly = 1;
    b_log = lane_log.size();
    issue(6, 2, 3, 4, 8'h22);
    wait_done("rr", 80);
    @(negedge clk);
    lane_busy = '0;
    chk("rr_ndisp", lane_log.size() - b_log, 6);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      chk("rr_lane", lane_log[b_log + i], exp_rr[i]);
      if (lane_log[b_log + i] == 1) bad++;
    end
    chk("rr_lane1_strobes", bad, 0);

    // credit limit with all lanes busy
    lane_busy = 4'hF;
    b_req = req_tot;
    b_log = lane_log.size();
    issue(8, 5, 6, 7, 8'h33);
    repeat (12) @(negedge clk);
    chk("cr_req4", req_tot - b_req, 4);
    chk("cr_vld_low", rd_req_vld, 0);
    chk("cr_no_disp", lane_log.size() - b_log, 0);
    dly = 30;
    lane_busy = 4'b1110;
    repeat (10) @(negedge clk);
    chk("cr_req5", req_tot - b_req, 5);
    chk("cr_vld_low2", rd_req_vld, 0);
    chk("cr_one_disp", lane_log.size() - b_log, 1);
    chk("cr_lane0", lane_log[b_log], 0);
    lane_busy = '0;
    dly = 2;
    wait_done("cr", 200);
    chk("cr_ndisp", lane_log.size() - b_log, 8);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (idx_log[b_log + i] != LW'(i)) bad++;
    chk("cr_idx_order", bad, 0);

    // request stall hold
    dly  = 1;
    b_req = req_tot;
    b_rl  = req_log.size();
    b_log = lane_log.size();
    issue(8, 1, 2, 3, 8'h44);
    n = 0;
    while (req_tot - b_req < 3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("st_reach3", req_tot - b_req, 3);
    rd_req_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("st_vld", rd_req_vld, 1);
      chk("st_idx", rd_req_idx, 3);
      chk("st_ptr0", rd_req_ptr0, 1);
      chk("st_ptr1", rd_req_ptr1, 2);
    end
    rd_req_rdy = 1'b1;
    wait_done("st", 100);
    chk("st_nreq", req_log.size() - b_rl, 8);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (req_log[b_rl + i] != LW'(i)) bad++;
      if (idx_log[b_log + i] != LW'(i)) bad++;
    end
    chk("st_idx_seq", bad, 0);

    // spurious response, then reset during drain
    @(negedge clk);
    inj_rsp = 1'b1;
    @(negedge clk);
    inj_rsp = 1'b0;
    chk("err_rsp_set", err, 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);
    dly = 6;
    b_log = lane_log.size();
    issue(8, 8, 9, 10, 8'h55);
    n = 0;
    while (lane_log.size() - b_log < 8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rs_all_disp", lane_log.size() - b_log, 8);
    chk("rs_in_drain", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_cmd_rdy", cmd_rdy, 1);
    chk("rs_req_vld", rd_req_vld, 0);
    chk("rs_req_idx", rd_req_idx, 0);
    chk("rs_ptr0", rd_req_ptr0, 0);
    chk("rs_lane_vld", lane_vld, 0);
    chk("rs_lane_data0", lane_data0, 0);
    chk("rs_lane_idx", lane_idx, 0);
    chk("rs_lane_op", lane_op, 0);
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    chk("rs_err", err, 0);
    reset = 1'b0;
    b_done = done_cnt;
    repeat (12) @(negedge clk);
    chk("rs_no_done", done_cnt - b_done, 0);
    chk("rs_err_clear", err, 0);

    // fresh command after reset
    dly = 2;
    b_log = lane_log.size();
    issue(2, 1, 1, 2, 8'h66);
    wait_done("post", 60);
    chk("post_ndisp", lane_log.size() - b_log, 2);
    chk("post_lane0", lane_log[b_log], 0);
    chk("post_lane1", lane_log[b_log + 1], 1);
    chk("post_err", err, 0);

    // spurious lane completion
    @(negedge clk);
    inj_done = 4'b0100;
    @(negedge clk);
    inj_done = '0;
    chk("err_done_set", err, 1);

    chk("data_fields", data_bad, 0);
    chk("onehot", hot_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
